// File: rtl/halut_pkg.sv
// Shared HALUT configuration and the decoder scheduler state type.
package halut_pkg;

    localparam int C            = 32;
    localparam int K            = 16;
    localparam int M            = 32;
    localparam int DecoderUnits = 16;

    localparam int MPerUnit     = M / DecoderUnits;
    localparam int CIdxWidth    = $clog2(C);
    localparam int KIdxWidth    = $clog2(K);
    localparam int MIdxWidth    = (MPerUnit > 1) ? $clog2(MPerUnit) : 1;
    localparam int UnitIdxWidth = $clog2(DecoderUnits);

    typedef enum logic [1:0] {
        SchedAccum,
        SchedIssue,
        SchedFlush,
        SchedDrain
    } sched_state_e;

endpackage

// File: rtl/halut_decoder_scheduler.sv
// Sequences one input row through the HALUT decoder array: accepts (c,k)
// pairs in codebook order, broadcasts each pair once per column owned by a
// decoder unit, waits for the decoder pipeline to flush, then streams out
// every accumulated column through a valid/ready read port.
module halut_decoder_scheduler #(
    parameter  int C            = halut_pkg::C,
    parameter  int K            = halut_pkg::K,
    parameter  int M            = halut_pkg::M,
    parameter  int DecoderUnits = halut_pkg::DecoderUnits,
    parameter  int DecLatency   = 2,
    localparam int MPerUnit     = M / DecoderUnits,
    localparam int CIdxWidth    = $clog2(C),
    localparam int KIdxWidth    = $clog2(K),
    localparam int MIdxWidth    = (MPerUnit > 1) ? $clog2(MPerUnit) : 1,
    localparam int UnitIdxWidth = $clog2(DecoderUnits),
    localparam int MGlobWidth   = $clog2(M)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    enc_valid_i,
    output logic                    enc_ready_o,
    input  logic [CIdxWidth-1:0]    enc_c_i,
    input  logic [KIdxWidth-1:0]    enc_k_i,
    output logic                    dec_valid_o,
    output logic [CIdxWidth-1:0]    dec_c_o,
    output logic [KIdxWidth-1:0]    dec_k_o,
    output logic [MIdxWidth-1:0]    dec_m_o,
    output logic                    dec_first_o,
    output logic                    dec_last_o,
    output logic                    rd_valid_o,
    input  logic                    rd_ready_i,
    output logic [UnitIdxWidth-1:0] rd_unit_o,
    output logic [MIdxWidth-1:0]    rd_m_o,
    output logic [MGlobWidth-1:0]   rd_idx_o,
    output logic                    rd_last_o,
    output logic [15:0]             rows_done_o,
    output logic                    seq_err_o
);

    import halut_pkg::*;

    localparam int FlushWidth = (DecLatency > 1) ? $clog2(DecLatency) : 1;

    // Columns must split evenly across units so every derived index is in range.
    if (M % DecoderUnits != 0) begin : g_param_check
        $error("halut_decoder_scheduler: M must be a multiple of DecoderUnits");
    end

    sched_state_e              r_state,     w_state_next;
    logic [CIdxWidth-1:0]      r_c_cnt,     w_c_cnt_next;
    logic [KIdxWidth-1:0]      r_k,         w_k_next;
    logic [MIdxWidth-1:0]      r_m_sub,     w_m_sub_next;
    logic [FlushWidth-1:0]     r_flush_cnt, w_flush_cnt_next;
    logic [MGlobWidth-1:0]     r_rd_idx,    w_rd_idx_next;
    logic [15:0]               r_rows_done, w_rows_done_next;
    logic                      r_seq_err,   w_seq_err_next;

    logic                      w_enc_ready;
    logic                      w_dec_valid;
    logic                      w_rd_valid;
    logic                      w_last_sub;
    logic                      w_last_c;
    logic [CIdxWidth-1:0]      w_c_inc;

    // State and counter registers; reset drops any partially processed row.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= SchedAccum;
            r_c_cnt     <= '0;
            r_k         <= '0;
            r_m_sub     <= '0;
            r_flush_cnt <= '0;
            r_rd_idx    <= '0;
            r_rows_done <= '0;
            r_seq_err   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_c_cnt     <= w_c_cnt_next;
            r_k         <= w_k_next;
            r_m_sub     <= w_m_sub_next;
            r_flush_cnt <= w_flush_cnt_next;
            r_rd_idx    <= w_rd_idx_next;
            r_rows_done <= w_rows_done_next;
            r_seq_err   <= w_seq_err_next;
        end
    end

    // Next-state logic: the codebook index always comes from c_cnt, never from the encoder.
    always_comb begin
        w_state_next     = r_state;
        w_c_cnt_next     = r_c_cnt;
        w_k_next         = r_k;
        w_m_sub_next     = r_m_sub;
        w_flush_cnt_next = r_flush_cnt;
        w_rd_idx_next    = r_rd_idx;
        w_rows_done_next = r_rows_done;
        w_seq_err_next   = r_seq_err;
        w_enc_ready      = 1'b0;
        w_dec_valid      = 1'b0;
        w_rd_valid       = 1'b0;
        w_last_sub       = (r_m_sub == MIdxWidth'(MPerUnit - 1));
        w_last_c         = (r_c_cnt == CIdxWidth'(C - 1));
        w_c_inc          = r_c_cnt + CIdxWidth'(1);

        case (r_state)
            SchedAccum: begin
                w_enc_ready = 1'b1;
                if (enc_valid_i) begin
                    w_k_next     = enc_k_i;
                    w_m_sub_next = '0;
                    w_state_next = SchedIssue;
                    if (enc_c_i != r_c_cnt) begin
                        w_seq_err_next = 1'b1;
                    end
                end
            end
            SchedIssue: begin
                w_dec_valid = 1'b1;
                if (!w_last_sub) begin
                    w_m_sub_next = r_m_sub + MIdxWidth'(1);
                end else if (!w_last_c) begin
                    w_enc_ready  = 1'b1;
                    w_c_cnt_next = w_c_inc;
                    w_m_sub_next = '0;
                    if (enc_valid_i) begin
                        w_k_next = enc_k_i;
                        if (enc_c_i != w_c_inc) begin
                            w_seq_err_next = 1'b1;
                        end
                    end else begin
                        w_state_next = SchedAccum;
                    end
                end else begin
                    w_c_cnt_next     = '0;
                    w_m_sub_next     = '0;
                    w_flush_cnt_next = '0;
                    w_state_next     = (DecLatency > 0) ? SchedFlush : SchedDrain;
                end
            end
            SchedFlush: begin
                if (r_flush_cnt == FlushWidth'(DecLatency - 1)) begin
                    w_flush_cnt_next = '0;
                    w_state_next     = SchedDrain;
                end else begin
                    w_flush_cnt_next = r_flush_cnt + FlushWidth'(1);
                end
            end
            SchedDrain: begin
                w_rd_valid = 1'b1;
                if (rd_ready_i) begin
                    if (r_rd_idx == MGlobWidth'(M - 1)) begin
                        w_rd_idx_next    = '0;
                        w_rows_done_next = r_rows_done + 16'd1;
                        w_state_next     = SchedAccum;
                    end else begin
                        w_rd_idx_next = r_rd_idx + MGlobWidth'(1);
                    end
                end
            end
            default: begin
                w_state_next = SchedAccum;
            end
        endcase
    end

    // Output mapping; drain address splits the global column into (unit, column).
    always_comb begin
        enc_ready_o = w_enc_ready;
        dec_valid_o = w_dec_valid;
        dec_c_o     = r_c_cnt;
        dec_k_o     = r_k;
        dec_m_o     = r_m_sub;
        dec_first_o = w_dec_valid && (r_c_cnt == '0);
        dec_last_o  = w_dec_valid && w_last_c;
        rd_valid_o  = w_rd_valid;
        rd_idx_o    = r_rd_idx;
        rd_unit_o   = UnitIdxWidth'(r_rd_idx / MGlobWidth'(MPerUnit));
        rd_m_o      = MIdxWidth'(r_rd_idx % MGlobWidth'(MPerUnit));
        rd_last_o   = w_rd_valid && (r_rd_idx == MGlobWidth'(M - 1));
        rows_done_o = r_rows_done;
        seq_err_o   = r_seq_err;
    end

endmodule

// File: tb/tb_halut_decoder_scheduler.sv
// Bench for halut_decoder_scheduler: a queue-based model of the issue and
// drain streams for the default configuration, plus a directed run of the
// one-column-per-unit, zero-latency configuration.
module tb_halut_decoder_scheduler;

    localparam int TbC   = 32;
    localparam int TbK   = 16;
    localparam int TbM   = 32;
    localparam int TbDU  = 16;
    localparam int TbDL  = 2;
    localparam int TbMPU = TbM / TbDU;
    localparam int Tb2M  = 16;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    // default-configuration instance
    logic        encValid = 1'b0;
    logic        encReady;
    logic [4:0]  encC = '0;
    logic [3:0]  encK = '0;
    logic        decValid;
    logic [4:0]  decC;
    logic [3:0]  decK;
    logic [0:0]  decM;
    logic        decFirst, decLast;
    logic        rdValid;
    logic        rdReady = 1'b0;
    logic [3:0]  rdUnit;
    logic [0:0]  rdM;
    logic [4:0]  rdIdx;
    logic        rdLast;
    logic [15:0] rowsDone;
    logic        seqErr;

    // MPerUnit=1, DecLatency=0 instance
    logic        encValid2 = 1'b0;
    logic        encReady2;
    logic [4:0]  encC2 = '0;
    logic [3:0]  encK2 = '0;
    logic        decValid2;
    logic [4:0]  decC2;
    logic [3:0]  decK2;
    logic [0:0]  decM2;
    logic        decFirst2, decLast2;
    logic        rdValid2;
    logic        rdReady2 = 1'b0;
    logic [3:0]  rdUnit2;
    logic [0:0]  rdM2;
    logic [3:0]  rdIdx2;
    logic        rdLast2;
    logic [15:0] rowsDone2;
    logic        seqErr2;

    halut_decoder_scheduler #(
        .C(TbC), .K(TbK), .M(TbM), .DecoderUnits(TbDU), .DecLatency(TbDL)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .enc_valid_i(encValid), .enc_ready_o(encReady), .enc_c_i(encC), .enc_k_i(encK),
        .dec_valid_o(decValid), .dec_c_o(decC), .dec_k_o(decK), .dec_m_o(decM),
        .dec_first_o(decFirst), .dec_last_o(decLast),
        .rd_valid_o(rdValid), .rd_ready_i(rdReady), .rd_unit_o(rdUnit), .rd_m_o(rdM),
        .rd_idx_o(rdIdx), .rd_last_o(rdLast), .rows_done_o(rowsDone), .seq_err_o(seqErr)
    );

    halut_decoder_scheduler #(
        .C(TbC), .K(TbK), .M(Tb2M), .DecoderUnits(Tb2M), .DecLatency(0)
    ) dutSmall (
        .clk_i(clk), .rst_ni(rst_ni),
        .enc_valid_i(encValid2), .enc_ready_o(encReady2), .enc_c_i(encC2), .enc_k_i(encK2),
        .dec_valid_o(decValid2), .dec_c_o(decC2), .dec_k_o(decK2), .dec_m_o(decM2),
        .dec_first_o(decFirst2), .dec_last_o(decLast2),
        .rd_valid_o(rdValid2), .rd_ready_i(rdReady2), .rd_unit_o(rdUnit2), .rd_m_o(rdM2),
        .rd_idx_o(rdIdx2), .rd_last_o(rdLast2), .rows_done_o(rowsDone2), .seq_err_o(seqErr2)
    );

    int assertCount = 0;
    int failCount   = 0;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        assertCount++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Model: every accepted (c,k) becomes MPerUnit queued issue beats; once the
    // whole row has issued, DecLatency idle cycles, then M drain beats.
    typedef struct {
        int c;
        int k;
        int m;
    } issue_t;

    issue_t issueQ[$];
    issue_t headItem;
    int     accRow    = 0;
    int     flushLeft = 0;
    int     drainIdx  = 0;
    int     mRows     = 0;
    bit     draining  = 0;
    bit     mSeqErr   = 0;
    bit     expReady, accept, popped;

    int statIssue, statRun, statMaxRun, statFirst, statLast, statGap, statDrain;
    bit statSawIssue, statSawDrain;

    // Per-cycle compare against the model, then advance the model by one edge.
    always @(negedge clk) begin
        #2;
        if (!rst_ni) begin
            issueQ.delete();
            accRow = 0; flushLeft = 0; drainIdx = 0; mRows = 0; draining = 0; mSeqErr = 0;
            checkOutput("reset enc_ready_o", encReady, 1);
            checkOutput("reset dec_valid_o", decValid, 0);
            checkOutput("reset dec_c_o", decC, 0);
            checkOutput("reset dec_first_o", decFirst, 0);
            checkOutput("reset rd_valid_o", rdValid, 0);
            checkOutput("reset rd_idx_o", rdIdx, 0);
            checkOutput("reset rows_done_o", rowsDone, 0);
            checkOutput("reset seq_err_o", seqErr, 0);
        end else begin
            expReady = !draining && (flushLeft == 0) && (accRow < TbC) && (issueQ.size() <= 1);
            checkOutput("enc_ready_o", encReady, expReady);
            checkOutput("dec_valid_o", decValid, issueQ.size() > 0);
            if (issueQ.size() > 0) begin
                headItem = issueQ[0];
                checkOutput("dec_c_o", decC, headItem.c);
                checkOutput("dec_k_o", decK, headItem.k);
                checkOutput("dec_m_o", decM, headItem.m);
                checkOutput("dec_first_o", decFirst, headItem.c == 0);
                checkOutput("dec_last_o", decLast, headItem.c == TbC - 1);
            end
            checkOutput("rd_valid_o", rdValid, draining);
            if (draining) begin
                checkOutput("rd_idx_o", rdIdx, drainIdx);
                checkOutput("rd_unit_o", rdUnit, drainIdx / TbMPU);
                checkOutput("rd_m_o", rdM, drainIdx % TbMPU);
                checkOutput("rd_last_o", rdLast, drainIdx == TbM - 1);
            end
            checkOutput("rows_done_o", rowsDone, mRows);
            checkOutput("seq_err_o", seqErr, mSeqErr);

            if (decValid) begin
                statIssue++; statRun++; statSawIssue = 1;
                if (statRun > statMaxRun) statMaxRun = statRun;
                if (decFirst) statFirst++;
                if (decLast) statLast++;
            end else begin
                statRun = 0;
            end
            if (rdValid) statSawDrain = 1;
            if (!decValid && !rdValid && statSawIssue && !statSawDrain) statGap++;
            if (rdValid && rdReady) statDrain++;

            accept = encValid && expReady;
            if (draining) begin
                if (rdReady) begin
                    if (drainIdx == TbM - 1) begin
                        draining = 0; drainIdx = 0; accRow = 0;
                        mRows = (mRows + 1) % 65536;
                    end else begin
                        drainIdx++;
                    end
                end
            end else if (flushLeft > 0) begin
                flushLeft--;
                if (flushLeft == 0) draining = 1;
            end else begin
                popped = issueQ.size() > 0;
                if (popped) void'(issueQ.pop_front());
                if (accept) begin
                    if (int'(encC) != accRow) mSeqErr = 1;
                    for (int m = 0; m < TbMPU; m++) issueQ.push_back('{accRow, int'(encK), m});
                    accRow++;
                end else if (popped && issueQ.size() == 0 && accRow == TbC) begin
                    if (TbDL > 0) flushLeft = TbDL;
                    else draining = 1;
                end
            end
        end
    end

    // Drives encoder and read ports until rows_done_o reaches targetRows.
    task automatic applyStimulus(input int targetRows, input int validPct, input int readyPct,
                                 input int badAt, input int resetAt);
        int cur = 0;
        int rowIdx = 0;
        int cyc = 0;
        int hold = 0;
        bit didReset = 0;
        bit lastV = 0;
        bit lastR = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (lastV && lastR) begin
                cur++;
                if (cur == TbC) begin
                    cur = 0;
                    rowIdx++;
                end
            end
            if (hold > 0) begin
                hold--;
                if (hold == 0) rst_ni = 1'b1;
            end
            if (rowsDone == 16'(targetRows) && rst_ni && (resetAt < 0 || didReset)) break;
            if (cyc > 4000) begin
                checkOutput("row completion timeout", rowsDone, targetRows);
                break;
            end
            if (resetAt >= 0 && !didReset && cur == resetAt && decValid) begin
                rst_ni = 1'b0;
                didReset = 1;
                hold = 2;
                cur = 0;
            end
            encValid = rst_ni && ($urandom_range(99) < validPct);
            encC     = 5'((cur == badAt) ? cur + 1 : cur);
            encK     = 4'((cur * 5 + rowIdx * 3) % TbK);
            rdReady  = rst_ni && ($urandom_range(99) < readyPct);
            lastV    = encValid;
            lastR    = encReady;
        end
        encValid = 1'b0;
        rdReady  = 1'b0;
    endtask

    // One row through the MPerUnit=1, DecLatency=0 instance with literal expectations.
    task automatic runSmallConfig();
        int cur = 0;
        int cyc = 0;
        int issues = 0;
        int run = 0;
        int maxRun = 0;
        int lastIssueCyc = -10;
        int firstRdCyc = -1;
        int drained = 0;
        bit lastV = 0;
        bit lastR = 0;
        rdReady2 = 1'b1;
        while (rowsDone2 != 16'd1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (lastV && lastR) cur++;
            if (decValid2) begin
                checkOutput("small dec_c_o", decC2, issues);
                checkOutput("small dec_m_o", decM2, 0);
                issues++;
                run++;
                if (run > maxRun) maxRun = run;
                lastIssueCyc = cyc;
            end else begin
                run = 0;
            end
            if (rdValid2) begin
                if (firstRdCyc < 0) firstRdCyc = cyc;
                checkOutput("small rd_idx_o", rdIdx2, drained);
                checkOutput("small rd_unit_o", rdUnit2, drained);
                checkOutput("small rd_last_o", rdLast2, drained == Tb2M - 1);
                drained++;
            end
            encValid2 = (cur < TbC);
            encC2     = 5'(cur);
            encK2     = 4'(cur % TbK);
            lastV     = encValid2;
            lastR     = encReady2;
        end
        encValid2 = 1'b0;
        rdReady2  = 1'b0;
        checkOutput("small issue count", issues, 32);
        checkOutput("small issue run", maxRun, 32);
        checkOutput("small drain right after last issue", firstRdCyc, lastIssueCyc + 1);
        checkOutput("small drain count", drained, 16);
        checkOutput("small rows_done_o", rowsDone2, 1);
        checkOutput("small seq_err_o", seqErr2, 0);
    endtask

    // Test sequence: reset, full-rate row, backpressured rows, sequence error, mid-row reset, small config.
    initial begin
        rst_ni = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("pin reset enc_ready_o", encReady, 1);
        checkOutput("pin reset dec_valid_o", decValid, 0);
        checkOutput("pin reset rows_done_o", rowsDone, 0);
        rst_ni = 1'b1;

        statIssue = 0; statRun = 0; statMaxRun = 0; statFirst = 0; statLast = 0;
        statGap = 0; statDrain = 0; statSawIssue = 0; statSawDrain = 0;
        applyStimulus(1, 100, 100, -1, -1);
        checkOutput("pin issue cycles", statIssue, 64);
        checkOutput("pin issue run", statMaxRun, 64);
        checkOutput("pin first cycles", statFirst, 2);
        checkOutput("pin last cycles", statLast, 2);
        checkOutput("pin flush cycles", statGap, 2);
        checkOutput("pin drain results", statDrain, 32);
        checkOutput("pin rows after row 1", rowsDone, 1);

        applyStimulus(3, 60, 50, -1, -1);
        checkOutput("pin rows after row 3", rowsDone, 3);

        applyStimulus(4, 100, 70, 4, -1);
        checkOutput("pin seq_err after bad c", seqErr, 1);
        checkOutput("pin rows after bad row", rowsDone, 4);

        applyStimulus(1, 100, 100, -1, 11);
        checkOutput("pin rows after reset row", rowsDone, 1);
        checkOutput("pin seq_err after reset", seqErr, 0);

        runSmallConfig();

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
